// File: rtl/darkfetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// darkfetch_if : pc feedback, imem handshake and decoder bundle of darkfetch
// Rev 1.0
// ----------------------------------------------------------------------------
interface darkfetch_if;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] nxpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  modport master (
    input  pc, imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    output pc_en, nxpc, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );

  modport slave (
    output pc, imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    input  pc_en, nxpc, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/darkfetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// darkfetch : instruction fetch sequencer with a DEPTH-entry instruction FIFO
// Rev 1.0   optional: DARKFETCH_ALIGN_CHECK_EN (misaligned redirect fault)
// ----------------------------------------------------------------------------
module darkfetch #(
  parameter int DEPTH  = 2,
  parameter int PC_INC = 4
) (
  input  logic       clk,
  input  logic       res,
  darkfetch_if.master bus
);

  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          req;
  logic          drop;
  logic [31:0]   req_pc;
  logic [CW-1:0] count, count_nx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic active, gnt_take, push, pop, flush;

`ifdef DARKFETCH_ALIGN_CHECK_EN
  logic fault;
  logic misalign;
  assign misalign        = flush && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_fault = fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    active   = (state != BOOT);
    flush    = active && bus.redirect;
    gnt_take = (state == REQ) && bus.imem_gnt;
    push     = (state == WAIT) && bus.imem_rvalid && !drop && !bus.redirect;
    pop      = bus.inst_valid && bus.inst_ready;
    count_nx = count + CW'(push) - CW'(pop);
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = bus.pc;
  assign bus.pc_en      = active && (bus.redirect || gnt_take);
  assign bus.nxpc       = bus.redirect ? {bus.redirect_pc[31:2], 2'b00}
                                       : bus.pc + 32'(PC_INC);
  assign bus.inst_valid = (count != '0) && !bus.redirect;
  assign bus.inst       = fifo_inst[rd_ptr];
  assign bus.inst_pc    = fifo_pc[rd_ptr];

  // A redirect always empties the FIFO, so every exit it forces lands in REQ.
  always_comb begin
    state_nx = state;
    case (state)
      BOOT: state_nx = REQ;
      REQ:  if (bus.imem_gnt) state_nx = WAIT;
      WAIT: if (bus.imem_rvalid)
              state_nx = (bus.redirect || count_nx < FULL) ? REQ : HOLD;
      HOLD: if (bus.redirect || count_nx < FULL) state_nx = REQ;
      default: state_nx = BOOT;
    endcase
`ifdef DARKFETCH_ALIGN_CHECK_EN
    if (fault || misalign) state_nx = HOLD;
`endif
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= BOOT;
      req    <= 1'b0;
      drop   <= 1'b0;
      req_pc <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      req   <= (state_nx == REQ);
      if (gnt_take) req_pc <= bus.pc;

      // drop marks the single in-flight response as belonging to a dead path
      if (gnt_take)
        drop <= bus.redirect;
      else if (state == WAIT) begin
        if (bus.imem_rvalid)   drop <= 1'b0;
        else if (bus.redirect) drop <= 1'b1;
      end

      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_nx;
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

`ifdef DARKFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) fault <= 1'b0;
    else if (misalign) fault <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_darkfetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_darkfetch : directed + randomized check of darkfetch against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_darkfetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  darkfetch_if bus();

  darkfetch #(.DEPTH(DEPTH), .PC_INC(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rs;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
  } stim_t;

  function automatic stim_t st(input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdr, input logic [31:0] rpc, input logic rdy);
    stim_t s;
    s.rs = 1'b0; s.g = g; s.rv = rv; s.rd = rd; s.rdr = rdr; s.rpc = rpc; s.rdy = rdy;
    return s;
  endfunction

  logic [31:0] pc_nx = 32'h0;
  logic        granted = 1'b0;
  int          mem_cnt = 0;

  // One clock cycle: inputs change just after the rising edge, the bench's PC
  // register and grant observation are taken at the falling edge.
  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1;
    res             = s.rs;
    bus.pc          = s.rs ? 32'h0 : pc_nx;
    bus.imem_gnt    = s.g;
    bus.imem_rvalid = s.rv;
    bus.imem_rdata  = s.rd;
    bus.redirect    = s.rdr;
    bus.redirect_pc = s.rpc;
    bus.inst_ready  = s.rdy;
    @(negedge clk);
    granted = bus.imem_req && bus.imem_gnt;
    pc_nx   = bus.pc_en ? bus.nxpc : bus.pc;
  endtask

  // Behavioural model: a queue of {pc, word}, one outstanding-request flag and
  // a flag saying whether a request may be issued in the coming cycle.
  logic [63:0] q[$];
  bit          booted = 0, outst = 0, drop_m = 0, m_req = 0;
  logic [31:0] rq_pc = 32'h0;

  always @(negedge clk) begin
    bit          e_valid, e_pc_en, was;
    logic [31:0] e_nxpc;
    if (res) begin
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      q.delete();
      booted = 0; outst = 0; drop_m = 0; m_req = 0;
    end else begin
      e_valid = (q.size() > 0) && !bus.redirect;
      e_pc_en = booted && (bus.redirect || (m_req && bus.imem_gnt));
      e_nxpc  = bus.redirect ? (bus.redirect_pc & 32'hFFFF_FFFC) : bus.pc + 32'd4;
      chk("m_imem_req", 32'(bus.imem_req), 32'(m_req));
      chk("m_imem_addr", bus.imem_addr, bus.pc);
      chk("m_pc_en", 32'(bus.pc_en), 32'(e_pc_en));
      if (e_pc_en) chk("m_nxpc", bus.nxpc, e_nxpc);
      chk("m_inst_valid", 32'(bus.inst_valid), 32'(e_valid));
      if (e_valid) begin
        chk("m_inst_pc", bus.inst_pc, q[0][63:32]);
        chk("m_inst", bus.inst, q[0][31:0]);
      end
      chk("m_fetch_fault", 32'(bus.fetch_fault), 32'd0);

      if (!booted) begin
        booted = 1;
      end else if (bus.redirect) begin
        q.delete();
        if (m_req && bus.imem_gnt) begin
          outst = 1; drop_m = 1;
        end else if (outst) begin
          if (bus.imem_rvalid) begin outst = 0; drop_m = 0; end
          else drop_m = 1;
        end
      end else begin
        was = outst;
        if (e_valid && bus.inst_ready) void'(q.pop_front());
        if (was && bus.imem_rvalid) begin
          if (!drop_m) q.push_back({rq_pc, bus.imem_rdata});
          drop_m = 0; outst = 0;
        end
        if (m_req && bus.imem_gnt) begin outst = 1; rq_pc = bus.pc; end
      end
      m_req = !outst && (q.size() < DEPTH);
    end
  end

  initial begin
    stim_t s;
    logic [31:0] r;
    bus.pc = 32'h0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
    #1 res = 1'b1;
    #2;
    chk("reset_req", 32'(bus.imem_req), 32'd0);
    chk("reset_valid", 32'(bus.inst_valid), 32'd0);
    s = st(0, 0, 0, 0, 0, 0); s.rs = 1'b1;
    cyc(s); cyc(s);

    // boot and first fetch
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("boot_no_req", 32'(bus.imem_req), 32'd0);
    chk("boot_no_pc_en", 32'(bus.pc_en), 32'd0);
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("first_pc_en", 32'(bus.pc_en), 32'd1);
    chk("first_nxpc", bus.nxpc, 32'h4);
    cyc(st(1, 1, 32'h13, 0, 0, 0));
    chk("wait_no_req", 32'(bus.imem_req), 32'd0);
    chk("wait_no_pc_en", 32'(bus.pc_en), 32'd0);
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("head_valid", 32'(bus.inst_valid), 32'd1);
    chk("head_inst", bus.inst, 32'h13);
    chk("head_pc", bus.inst_pc, 32'h0);
    chk("second_addr", bus.imem_addr, 32'h4);
    chk("second_nxpc", bus.nxpc, 32'h8);

    // fill to full, hold, pop releases the next request
    cyc(st(0, 1, 32'h17, 0, 0, 0));
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("hold_no_req", 32'(bus.imem_req), 32'd0);
    chk("hold_no_pc_en", 32'(bus.pc_en), 32'd0);
    cyc(st(1, 0, 0, 0, 0, 1));
    chk("hold_pop_no_req", 32'(bus.imem_req), 32'd0);
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("after_pop_req", 32'(bus.imem_req), 32'd1);
    chk("after_pop_addr", bus.imem_addr, 32'h8);
    chk("after_pop_head", bus.inst_pc, 32'h4);
    chk("after_pop_inst", bus.inst, 32'h17);

    // redirect while waiting: response discarded, FIFO flushed
    cyc(st(0, 0, 0, 1, 32'h100, 1));
    chk("rdw_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rdw_nxpc", bus.nxpc, 32'h100);
    chk("rdw_valid", 32'(bus.inst_valid), 32'd0);
    cyc(st(0, 1, 32'hDEAD0000, 0, 0, 1));
    chk("rdw_drop_valid", 32'(bus.inst_valid), 32'd0);
    cyc(st(1, 0, 0, 0, 0, 1));
    chk("rdw_addr", bus.imem_addr, 32'h100);
    chk("rdw_req", 32'(bus.imem_req), 32'd1);
    chk("rdw_empty", 32'(bus.inst_valid), 32'd0);
    cyc(st(0, 1, 32'h113, 0, 0, 0));
    cyc(st(0, 0, 0, 0, 0, 0));
    chk("rdw_head_pc", bus.inst_pc, 32'h100);
    chk("rdw_head_inst", bus.inst, 32'h113);

    // redirect in the grant cycle
    cyc(st(1, 0, 0, 1, 32'h200, 1));
    chk("rdg_nxpc", bus.nxpc, 32'h200);
    chk("rdg_valid", 32'(bus.inst_valid), 32'd0);
    cyc(st(0, 1, 32'hBAD, 0, 0, 1));
    chk("rdg_drop_valid", 32'(bus.inst_valid), 32'd0);
    cyc(st(0, 0, 0, 0, 0, 1));
    chk("rdg_addr", bus.imem_addr, 32'h200);
    chk("rdg_req", 32'(bus.imem_req), 32'd1);

    // pc wrap
    cyc(st(0, 0, 0, 1, 32'hFFFF_FFFC, 0));
    cyc(st(1, 0, 0, 0, 0, 0));
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_nxpc", bus.nxpc, 32'h0);

    // asynchronous reset while a response is pending
    cyc(st(0, 0, 0, 0, 0, 0));
    #1 bus.redirect = 1'b1;
    #1 res = 1'b1;
    #1;
    chk("async_pc_en", 32'(bus.pc_en), 32'd0);
    chk("async_req", 32'(bus.imem_req), 32'd0);
    s = st(0, 0, 0, 0, 0, 0); s.rs = 1'b1;
    cyc(s);
    cyc(st(0, 1, 32'h5555, 0, 0, 0));
    chk("post_rst_boot", 32'(bus.imem_req), 32'd0);
    cyc(st(0, 1, 32'h6666, 0, 0, 0));
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    cyc(st(1, 0, 0, 0, 0, 0));
    cyc(st(0, 1, 32'h77, 0, 0, 0));
    cyc(st(0, 0, 0, 0, 0, 0));
    chk("stale_ignored_inst", bus.inst, 32'h77);
    chk("stale_ignored_pc", bus.inst_pc, 32'h0);

    // randomized traffic against the model
    mem_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      s = st(0, 0, 32'($urandom), 0, 0, 0);
      s.rs = ($urandom_range(0, 599) == 0);
      s.g  = ($urandom_range(0, 2) != 0);
      if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) s.rv = 1'b1;
      end
      s.rdr = ($urandom_range(0, 14) == 0);
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       s.rpc = r;
        1:       s.rpc = 32'hFFFF_FFF0 | (r & 32'hC);
        default: s.rpc = r & 32'hFFFF_FFFC;
      endcase
      s.rdy = ($urandom_range(0, 1) == 1);
      cyc(s);
      if (granted) mem_cnt = $urandom_range(1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
